// File: rtl/ifft_seq.sv
// Sequential radix-2 DIT inverse FFT: bit-reversed frame load, in-place butterflies, natural-order output.
// Optional 1/N output scaling is enabled by defining IFFT_SCALE_EN.
module ifft_seq #(
  parameter int SIZE       = 8,
  parameter int IN_BITS    = 32,
  parameter int OUT_BITS   = 32,
  parameter int RESOLUTION = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_BITS-1:0]  in_re,
  input  logic signed [IN_BITS-1:0]  in_im,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [OUT_BITS-1:0] out_re,
  output logic signed [OUT_BITS-1:0] out_im,
  output logic                       out_last,
  output logic                       busy
);

  localparam int LEVELS = $clog2(SIZE);
  localparam int AW     = LEVELS;
  localparam int BW     = LEVELS - 1;
  localparam int SW     = $clog2(LEVELS);
  localparam int TWB    = RESOLUTION + 2;
  localparam int PW     = OUT_BITS + TWB + 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;

  state_t         state;
  logic [AW-1:0]  idx;
  logic [SW-1:0]  stage;
  logic [BW-1:0]  bfly;

  logic signed [OUT_BITS-1:0] mem_re [SIZE];
  logic signed [OUT_BITS-1:0] mem_im [SIZE];

  logic signed [TWB-1:0] rom_cos [SIZE/2];
  logic signed [TWB-1:0] rom_sin [SIZE/2];

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Twiddle constants round(cos/sin(2*pi*m/SIZE) * 2^RESOLUTION), elaborated from a Taylor series.
  function automatic int tw_fix(input int m, input bit use_sin);
    real th, term, acc, scale;
    th    = 6.283185307179586 * real'(m) / real'(SIZE);
    term  = use_sin ? th : 1.0;
    acc   = 0.0;
    for (int n = 0; n < 24; n++) begin
      acc  = acc + term;
      term = use_sin ? -term * th * th / real'((2*n+2) * (2*n+3))
                     : -term * th * th / real'((2*n+1) * (2*n+2));
    end
    scale = 1.0;
    for (int r = 0; r < RESOLUTION; r++) scale = scale * 2.0;
    acc = acc * scale;
    return (acc >= 0.0) ? $rtoi(acc + 0.5) : -$rtoi(0.5 - acc);
  endfunction

  for (genvar g = 0; g < SIZE/2; g++) begin : g_rom
    assign rom_cos[g] = TWB'(tw_fix(g, 1'b0));
    assign rom_sin[g] = TWB'(tw_fix(g, 1'b1));
  end

  logic [AW-1:0] half, jj, top, bot;
  logic [BW-1:0] tw_idx;

  always_comb begin
    half   = AW'(1) << stage;
    jj     = AW'(bfly) & (half - AW'(1));
    top    = ((AW'(bfly) >> stage) << (stage + 1)) | jj;
    bot    = top | half;
    tw_idx = BW'(jj << (BW - int'(stage)));
  end

  logic signed [OUT_BITS-1:0] ar, ai, br, bi, tr, ti;
  logic signed [TWB-1:0]      wr, wi;
  logic signed [PW-1:0]       pr, pim;

  always_comb begin
    ar  = mem_re[top];
    ai  = mem_im[top];
    br  = mem_re[bot];
    bi  = mem_im[bot];
    wr  = rom_cos[tw_idx];
    wi  = rom_sin[tw_idx];
    pr  = PW'(br) * PW'(wr) - PW'(bi) * PW'(wi);
    pim = PW'(br) * PW'(wi) + PW'(bi) * PW'(wr);
    tr  = OUT_BITS'(pr >>> RESOLUTION);
    ti  = OUT_BITS'(pim >>> RESOLUTION);
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem_re[bitrev(idx)] <= OUT_BITS'(in_re);
      mem_im[bitrev(idx)] <= OUT_BITS'(in_im);
    end else if (state == COMPUTE) begin
      mem_re[top] <= ar + tr;
      mem_im[top] <= ai + ti;
      mem_re[bot] <= ar - tr;
      mem_im[bot] <= ai - ti;
    end
  end

  // Entry 0 is never touched by the final butterfly (it writes SIZE/2-1 and SIZE-1),
  // so the first sample can be captured on the same edge as that write.
  logic [AW-1:0]              rd_addr;
  logic signed [OUT_BITS-1:0] rd_re, rd_im, sc_re, sc_im;

  always_comb begin
    rd_addr = (state == OUT) ? idx + AW'(1) : '0;
    rd_re   = mem_re[rd_addr];
    rd_im   = mem_im[rd_addr];
  end

`ifdef IFFT_SCALE_EN
  assign sc_re = rd_re >>> LEVELS;
  assign sc_im = rd_im >>> LEVELS;
`else
  assign sc_re = rd_re;
  assign sc_im = rd_im;
`endif

  assign in_ready = (state == LOAD);
  assign busy     = (state != LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      idx       <= '0;
      stage     <= '0;
      bfly      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid) begin
            idx <= idx + AW'(1);
            if (idx == AW'(SIZE - 1)) state <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (bfly == '1) begin
            bfly <= '0;
            if (stage == SW'(LEVELS - 1)) begin
              stage     <= '0;
              state     <= OUT;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              out_re    <= sc_re;
              out_im    <= sc_im;
            end else begin
              stage <= stage + SW'(1);
            end
          end else begin
            bfly <= bfly + BW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            if (idx == AW'(SIZE - 1)) begin
              state     <= LOAD;
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              idx      <= idx + AW'(1);
              out_re   <= sc_re;
              out_im   <= sc_im;
              out_last <= (idx == AW'(SIZE - 2));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft_seq.sv
// Directed-vector bench for ifft_seq (SIZE=8, RESOLUTION=8); expectations follow IFFT_SCALE_EN.
module tb_ifft_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_re, in_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_re, out_im;
  logic               out_last;
  logic               busy;

  ifft_seq #(.SIZE(8), .IN_BITS(32), .OUT_BITS(32), .RESOLUTION(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miscompares = 0;

  int xr [8], xi [8];
  int got_re [8], got_im [8];
  logic got_last [8];
  int got_n, stall_changes;
  logic timed_out;

  // Raw tone spectrum X[1]=256: 256*exp(+j*pi*n/4) with 8-bit twiddles.
  int tone_re [8] = '{256, 181, 0, -181, -256, -181, 0, 181};
  int tone_im [8] = '{0, 181, 256, 181, 0, -181, -256, -181};

  function automatic int scl(input int v);
`ifdef IFFT_SCALE_EN
    return v >>> 3;
`else
    return v;
`endif
  endfunction

  task automatic set_bins(input int k1, input int re1, input int dflt);
    for (int k = 0; k < 8; k++) begin
      xr[k] = (k == k1) ? re1 : dflt;
      xi[k] = 0;
    end
  endtask

  // Drives one frame; when hold_valid is set, in_valid stays high with junk until out_valid.
  task automatic send_frame(input bit hold_valid);
    int guard;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_re = xr[k]; in_im = xi[k];
      @(posedge clk); #1;
    end
    if (hold_valid) begin
      in_re = 999; in_im = -999; guard = 0;
      while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    end
    in_valid = 1'b0; in_re = 0; in_im = 0;
  endtask

  task automatic collect(input int stall_at, input int stall_len);
    int cyc;
    logic [64:0] snap;
    got_n = 0; cyc = 0; stall_changes = 0;
    out_ready = 1'b1;
    while (got_n < 8 && cyc < 300) begin
      if (out_valid) begin
        if (got_n == stall_at && stall_len > 0) begin
          snap = {out_re, out_im, out_last};
          out_ready = 1'b0;
          for (int i = 0; i < stall_len; i++) begin
            @(posedge clk); #1; cyc++;
            if ({out_re, out_im, out_last} !== snap || !out_valid) stall_changes++;
          end
          out_ready = 1'b1;
        end
        got_re[got_n] = out_re; got_im[got_n] = out_im; got_last[got_n] = out_last;
        got_n++;
      end
      @(posedge clk); #1; cyc++;
    end
    timed_out = (got_n < 8);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_re = 0; in_im = 0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({in_ready, out_valid, out_last, busy} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags got rdy/vld/last/busy=%b want 1000", {in_ready, out_valid, out_last, busy});
    end
    vec++;
    if (out_re !== 0 || out_im !== 0) begin
      miscompares++;
      $display("FAIL reset_data got (%0d,%0d) want (0,0)", out_re, out_im);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_dc;
    int lat;
    set_bins(0, 256, 0);
    send_frame(1'b0);
    vec++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL dc_enter_compute got in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    vec++;
    if (lat != 13) begin
      miscompares++;
      $display("FAIL dc_latency got %0d cycles want 13", lat);
    end
    collect(-1, 0);
    vec++;
    if (timed_out) begin
      miscompares++;
      $display("FAIL dc_timeout got %0d samples want 8", got_n);
    end
    for (int n = 0; n < 8; n++) begin
      vec++;
      if (got_re[n] !== scl(256) || got_im[n] !== 0 || got_last[n] !== (n == 7)) begin
        miscompares++;
        $display("FAIL dc_x%0d got (%0d,%0d,last=%b) want (%0d,0,last=%b)",
                 n, got_re[n], got_im[n], got_last[n], scl(256), (n == 7));
      end
    end
    vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dc_back_to_load got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_flat;
    set_bins(0, 8, 8);
    send_frame(1'b0);
    collect(-1, 0);
    vec++;
    if (timed_out) begin
      miscompares++;
      $display("FAIL flat_timeout got %0d samples want 8", got_n);
    end
    for (int n = 0; n < 8; n++) begin
      vec++;
      if (got_re[n] !== scl(n == 0 ? 64 : 0) || got_im[n] !== 0) begin
        miscompares++;
        $display("FAIL flat_x%0d got (%0d,%0d) want (%0d,0)", n, got_re[n], got_im[n], scl(n == 0 ? 64 : 0));
      end
    end
  endtask

  task automatic test_tone;
    set_bins(1, 256, 0);
    send_frame(1'b0);
    collect(-1, 0);
    vec++;
    if (timed_out) begin
      miscompares++;
      $display("FAIL tone_timeout got %0d samples want 8", got_n);
    end
    for (int n = 0; n < 8; n++) begin
      vec++;
      if (got_re[n] !== scl(tone_re[n]) || got_im[n] !== scl(tone_im[n])) begin
        miscompares++;
        $display("FAIL tone_x%0d got (%0d,%0d) want (%0d,%0d)",
                 n, got_re[n], got_im[n], scl(tone_re[n]), scl(tone_im[n]));
      end
    end
  endtask

  task automatic test_backpressure;
    set_bins(1, 256, 0);
    send_frame(1'b1);
    collect(3, 5);
    vec++;
    if (timed_out || stall_changes != 0) begin
      miscompares++;
      $display("FAIL bp_stall got samples=%0d changes=%0d want 8 0", got_n, stall_changes);
    end
    for (int n = 0; n < 8; n++) begin
      vec++;
      if (got_re[n] !== scl(tone_re[n]) || got_im[n] !== scl(tone_im[n]) || got_last[n] !== (n == 7)) begin
        miscompares++;
        $display("FAIL bp_x%0d got (%0d,%0d,last=%b) want (%0d,%0d,last=%b)",
                 n, got_re[n], got_im[n], got_last[n], scl(tone_re[n]), scl(tone_im[n]), (n == 7));
      end
    end
  endtask

  task automatic test_back_to_back;
    set_bins(0, 256, 0);
    send_frame(1'b0);
    collect(-1, 0);
    vec++;
    if (timed_out) begin
      miscompares++;
      $display("FAIL b2b_timeout got %0d samples want 8", got_n);
    end
    for (int n = 0; n < 8; n++) begin
      vec++;
      if (got_re[n] !== scl(256) || got_im[n] !== 0) begin
        miscompares++;
        $display("FAIL b2b_x%0d got (%0d,%0d) want (%0d,0)", n, got_re[n], got_im[n], scl(256));
      end
    end
  endtask

  task automatic test_reset_mid;
    set_bins(0, 256, 0);
    send_frame(1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_flags got vld=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_bins(1, 256, 0);
    send_frame(1'b0);
    collect(-1, 0);
    vec++;
    if (timed_out) begin
      miscompares++;
      $display("FAIL midreset_timeout got %0d samples want 8", got_n);
    end
    for (int n = 0; n < 8; n++) begin
      vec++;
      if (got_re[n] !== scl(tone_re[n]) || got_im[n] !== scl(tone_im[n])) begin
        miscompares++;
        $display("FAIL midreset_x%0d got (%0d,%0d) want (%0d,%0d)",
                 n, got_re[n], got_im[n], scl(tone_re[n]), scl(tone_im[n]));
      end
    end
  endtask

  initial begin
    test_reset;
    test_dc;
    test_flat;
    test_tone;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion want finish before 200000");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/ifft_seq.md
# ifft_seq

Sequential radix-2 decimation-in-time inverse FFT. It turns complex frequency bins into complex time-domain samples, and is the reconstruction counterpart of the combinational forward FFT in the signal-processing chain. It accepts one bin per cycle over a valid/ready stream and buffers a full frame. It computes in place with a single shared butterfly, then streams the samples out in natural order.

## Interface
- SIZE, 8, frame length; power of two, at least 4
- IN_BITS, 32, signed width of each input bin component
- OUT_BITS, 32, signed width of internal storage and outputs; must be at least IN_BITS
- RESOLUTION, 8, fractional bits of the twiddle constants

- clk  input  1  clock; all state is updated on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_re/in_im carry a bin
- in_ready  output  1  block accepts a bin this cycle
- in_re, in_im  input  IN_BITS each  signed bin X[k]; bins arrive in order k = 0..SIZE-1
- out_valid  output  1  out_re/out_im hold a sample
- out_ready  input  1  downstream accepts the sample
- out_re, out_im  output  OUT_BITS each  signed sample x[n]; samples leave in order n = 0..SIZE-1
- out_last  output  1  high together with out_valid on sample n = SIZE-1
- busy  output  1  high in the COMPUTE and OUT states

## Operation
- The FSM has three states: LOAD, COMPUTE and OUT. It resets to LOAD.
- LOAD:
  - in_ready = 1.
  - Each accepted bin (in_valid & in_ready) is sign-extended to OUT_BITS.
  - It is written to buffer address bitrev(k), where k is the accept count.
  - After the SIZE-th accept, the FSM moves to COMPUTE.
- COMPUTE:
  - Runs LEVELS = log2(SIZE) stages, each of SIZE/2 butterflies, at one butterfly per cycle.
  - Stage s, butterfly b: half = 2^s, group = b / half, j = b mod half.
  - Operand addresses: top = group*2*half + j, bot = top + half.
  - Twiddle W = exp(+j·2π·j/(2·half)); each component is a ROM constant round(cos/sin · 2^RESOLUTION).
  - t = (bot · W) >>> RESOLUTION, applied to re and im separately.
  - Products are computed at full width; the shift is arithmetic.
  - Results: top ← top + t, bot ← top − t.
  - All sums wrap in two's complement at OUT_BITS. There is no saturation.
- OUT:
  - Presents buffer[n] for n = 0..SIZE-1.
  - An entry advances only on out_valid & out_ready.
  - After the transfer of n = SIZE-1, the FSM returns to LOAD.
- in_valid outside LOAD is ignored and no data is taken.
- out_ready outside OUT is ignored.
- Asserting rst_n low mid-frame abandons the frame:
  - state returns to LOAD and all counters clear;
  - buffer contents are don't-care.

## Timing
- Values while in reset:
  - in_ready = 1 (combinational from the LOAD state)
  - out_valid = 0, out_last = 0, busy = 0
  - out_re = 0, out_im = 0
- Input bins may be back to back, one per cycle.
- The FSM enters COMPUTE on the cycle after the SIZE-th accept. in_ready is 0 from that cycle on.
- COMPUTE lasts exactly LEVELS·SIZE/2 cycles (12 for SIZE = 8).
- out_valid rises on the first OUT cycle.
- out_re, out_im and out_last are registered and stay stable while out_valid & !out_ready.
- With out_ready held high, one sample leaves per cycle.
- Latency from the last input accept to the first out_valid is LEVELS·SIZE/2 + 1 cycles.
- in_ready rises on the cycle after the last output transfer. No bubble is required beyond that cycle.

## Configuration
- IFFT_SCALE_EN defined:
  - each output component is the buffer value >>> LEVELS (arithmetic shift, truncates toward −∞);
  - this gives the true 1/N inverse.
- IFFT_SCALE_EN undefined:
  - outputs are raw buffer values, i.e. N·x[n];
  - no shift logic is present.

## Test plan
All cases use SIZE = 8 and RESOLUTION = 8. IFFT_SCALE_EN is defined unless stated otherwise.
- DC bin: X[0] = (256, 0), all other bins 0 → every output is (32, 0); out_last only on n = 7; first out_valid exactly 13 cycles after the 8th accept.
- Flat spectrum: X[k] = (8, 0) for all k → x[0] = (8, 0), x[1..7] = (0, 0).
- Tone: X[1] = (256, 0), others 0 → x[0] = (32, 0), x[2] = (0, 32), x[4] = (−32, 0), x[6] = (0, −32); odd n within ±1 of (±22.6, ±22.6) with matching signs.
- Backpressure: drop out_ready for 5 cycles while n = 3 is presented → out_re/out_im/out_last do not change; all 8 samples arrive once, in order. Holding in_valid = 1 during COMPUTE adds no bins.
- Reset mid-frame: rst_n low for 1 cycle during COMPUTE → immediately out_valid = 0, busy = 0, in_ready = 1; the next full frame gives correct results.
- IFFT_SCALE_EN undefined: the DC bin case gives every output (256, 0).
